// File: rtl/raster_sequencer.sv
// rtl/raster_sequencer.sv - frame raster walker feeding the sprite chain and the framebuffer write port
// Optional chain-timeout path is compiled in when RASTER_SEQ_TIMEOUT_EN is defined.
module raster_sequencer #(
  parameter int         H_RES         = 160,
  parameter int         V_RES         = 120,
  parameter logic [7:0] BG_COLOR      = 8'h00,
  parameter int         CHAIN_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic        program_active,
  input  logic        chain_enable_in,
  input  logic [7:0]  chain_rgb,
  output logic        chain_enable,
  output logic [7:0]  screenX,
  output logic [7:0]  screenY,
  output logic [7:0]  rgb_seed,
  output logic        fb_we,
  output logic [14:0] fb_addr,
  output logic [7:0]  fb_data,
  output logic        frame_busy,
  output logic        frame_done,
  output logic        timeout_err
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_WRITE, S_DONE} state_t;

  localparam logic [7:0] X_LAST = 8'(H_RES - 1);
  localparam logic [7:0] Y_LAST = 8'(V_RES - 1);

  if (H_RES < 1 || H_RES > 256 || V_RES < 1 || V_RES > 256 || H_RES * V_RES > 32768 ||
      CHAIN_TIMEOUT < 1 || CHAIN_TIMEOUT > 255) begin : g_bad_params
    $error("raster_sequencer: parameter out of range");
  end

  state_t      state_q, state_d;
  logic [7:0]  x_q, x_d, y_q, y_d;
  logic [14:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        busy_q, busy_d, done_q, done_d;
`ifdef RASTER_SEQ_TIMEOUT_EN
  localparam logic [7:0] WAIT_LAST = 8'(CHAIN_TIMEOUT - 1);
  logic [7:0]  wcnt_q, wcnt_d;
  logic        terr_q, terr_d;
`endif

  // Raster order makes the linear address a simple counter alongside x/y.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    addr_d  = addr_q;
    data_d  = data_q;
    done_d  = (state_q == S_DONE);
`ifdef RASTER_SEQ_TIMEOUT_EN
    wcnt_d  = wcnt_q;
    terr_d  = terr_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        x_d    = '0;
        y_d    = '0;
        addr_d = '0;
        if (frame_start) begin
          state_d = S_ISSUE;
`ifdef RASTER_SEQ_TIMEOUT_EN
          terr_d  = 1'b0;
`endif
        end
      end
      S_ISSUE: begin
        if (!program_active) state_d = S_WAIT;
`ifdef RASTER_SEQ_TIMEOUT_EN
        wcnt_d = '0;
`endif
      end
      S_WAIT: begin
        if (chain_enable_in) begin
          data_d  = chain_rgb;
          state_d = S_WRITE;
        end
`ifdef RASTER_SEQ_TIMEOUT_EN
        else if (wcnt_q == WAIT_LAST) begin
          data_d  = BG_COLOR;
          terr_d  = 1'b1;
          state_d = S_WRITE;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
`endif
      end
      S_WRITE: begin
        if (x_q == X_LAST && y_q == Y_LAST) begin
          x_d     = '0;
          y_d     = '0;
          addr_d  = '0;
          state_d = S_DONE;
        end else begin
          addr_d  = addr_q + 15'd1;
          state_d = S_ISSUE;
          if (x_q == X_LAST) begin
            x_d = '0;
            y_d = y_q + 8'd1;
          end else begin
            x_d = x_q + 8'd1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Busy stays up through the registered frame_done cycle.
    busy_d = (state_d != S_IDLE) || (state_q == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef RASTER_SEQ_TIMEOUT_EN
      wcnt_q  <= '0;
      terr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef RASTER_SEQ_TIMEOUT_EN
      wcnt_q  <= wcnt_d;
      terr_q  <= terr_d;
`endif
    end
  end

  assign chain_enable = (state_q == S_ISSUE) && !program_active;
  assign screenX      = x_q;
  assign screenY      = y_q;
  assign rgb_seed     = BG_COLOR;
  assign fb_we        = (state_q == S_WRITE);
  assign fb_addr      = addr_q;
  assign fb_data      = data_q;
  assign frame_busy   = busy_q;
  assign frame_done   = done_q;
`ifdef RASTER_SEQ_TIMEOUT_EN
  assign timeout_err  = terr_q;
`else
  assign timeout_err  = 1'b0;
`endif

endmodule

// File: doc/raster_sequencer.md
# raster_sequencer

Frame-level driver for the sprite engine chain. Walks every pixel of the frame and presents its coordinates and a background seed colour to the head of the chain. It waits for the tail's enable handshake, then writes the composited colour into the framebuffer through a single write port. It sits between the frame timing/control logic and the framebuffer memory, upstream and downstream of the chained sprite engines.

## Interface
Parameters:
- H_RES, 160: pixels per line; x range 0..H_RES-1.
- V_RES, 120: lines per frame; y range 0..V_RES-1. H_RES*V_RES must be ≤ 32768.
- BG_COLOR, 8'h00: seed colour driven into the head of the chain; also written on timeout.
- CHAIN_TIMEOUT, 255: maximum WAIT cycles before a pixel is abandoned (8-bit counter).

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- frame_start  in  1  request one frame render; sampled only in IDLE.
- program_active  in  1  sprite programming in progress; blocks issue of new pixels.
- chain_enable_in  in  1  tail enable_out: pixel result valid this cycle.
- chain_rgb  in  8  tail rgbout: composited colour.
- chain_enable  out  1  head prev_enable: one-cycle pixel-issue pulse.
- screenX  out  8  head x coordinate.
- screenY  out  8  head y coordinate.
- rgb_seed  out  8  head rgbin; constant BG_COLOR.
- fb_we  out  1  framebuffer write strobe.
- fb_addr  out  15  framebuffer word address.
- fb_data  out  8  framebuffer write data.
- frame_busy  out  1  high from leaving IDLE until return to IDLE.
- frame_done  out  1  one-cycle pulse at frame end.
- timeout_err  out  1  sticky: at least one pixel timed out this frame.

## Operation
- FSM states: IDLE, ISSUE, WAIT, WRITE, DONE. All outputs are Moore/registered.
- IDLE:
  - x=y=0.
  - frame_start=1 → ISSUE and clear timeout_err.
  - frame_start is ignored in every other state.
- ISSUE:
  - If program_active=1, stay in ISSUE with chain_enable=0.
  - Otherwise chain_enable=1 for exactly this cycle, screenX=x, screenY=y → WAIT. Clear the wait counter.
- WAIT:
  - chain_enable_in=1 → capture chain_rgb into fb_data → WRITE.
  - Otherwise increment the counter (RASTER_SEQ_TIMEOUT_EN only). When the counter reaches CHAIN_TIMEOUT: fb_data=BG_COLOR, set timeout_err → WRITE.
  - chain_enable_in is ignored outside WAIT.
- WRITE:
  - fb_we=1 for one cycle, fb_addr = y*H_RES + x (15-bit, no truncation by construction).
  - Then advance: x==H_RES-1 → x=0, y++; else x++.
  - If (x,y) was (H_RES-1,V_RES-1) → DONE, else → ISSUE.
- DONE: frame_done=1 for one cycle → IDLE.
- screenX/screenY hold their value outside ISSUE (they are not cleared in WAIT), so the chain sees stable coordinates.
- program_active is not sampled in WAIT or WRITE; an in-flight pixel always completes.

## Timing
- Reset values:
  - state=IDLE, x=y=0.
  - chain_enable=0, screenX=screenY=0, rgb_seed=BG_COLOR.
  - fb_we=0, fb_addr=0, fb_data=0.
  - frame_busy=0, frame_done=0, timeout_err=0.
- Reset mid-frame aborts immediately. No further fb_we. The next frame restarts at (0,0).
- frame_start high at edge t: ISSUE at cycle t+1 with chain_enable=1 (if program_active=0).
- Chain latency L ≥ 1 cycles (enable pulse to chain_enable_in). Cycles per pixel = L+2 when program_active=0. Zero-latency (combinational) chains are not supported.
- Frame length = H_RES*V_RES*(L+2) + 2 cycles (IDLE exit + DONE), plus program_active stall cycles.
- Timeout pixel: WAIT lasts exactly CHAIN_TIMEOUT cycles.

## Configuration
- RASTER_SEQ_TIMEOUT_EN defined: wait counter and timeout path compiled in, behaving as above.
- Undefined: no counter; WAIT exits only on chain_enable_in (may wait forever); timeout_err is tied to 0.

## Test plan
- Default params, model chain with L=3 returning rgb = x^y, frame_start pulse → 19200 writes; fb_addr 0..19199 in order; fb_data at addr 161 = 8'h00 (x=1,y=1); frame_done exactly 1 pulse at cycle 19200*5+2.
- H_RES=4, V_RES=2, L=1 → 8 writes, addr 0..7; addr 4 carries screenY=1, screenX=0; frame_busy high 26 cycles.
- H_RES=4, V_RES=2: program_active=1 for 10 cycles while in ISSUE at pixel 3 → no chain_enable during hold; total frame length +10; data unaffected.
- RASTER_SEQ_TIMEOUT_EN, CHAIN_TIMEOUT=8, chain never answers pixel (2,0) → WAIT 8 cycles, fb_data=BG_COLOR at addr 2, timeout_err=1 until next frame_start; remaining pixels normal.
- Reset asserted in WAIT of pixel 5 → all outputs at reset values next cycle; no fb_we; new frame_start begins at addr 0.
- frame_start pulsed every cycle during a frame → exactly one frame rendered; frame_done once.
